// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 active-low keypad scanner with row debounce and a one-key output buffer
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4,  // cycles each column is driven, >= 4
    parameter int DEBOUNCE_CYCLES = 8   // stable cycles to accept a press or release, >= 2
) (
    input  logic       clk,
    input  logic       RST,          // asynchronous, active-high
    input  logic [3:0] RowIn,        // keypad rows, active-low, asynchronous
    output logic [3:0] ColOut,       // active-low one-hot column drive
    output logic [3:0] key_code,     // row*4 + col of the buffered key
    output logic       key_valid,    // key_code holds an unread key
    input  logic       key_read,     // consumer acknowledge
    output logic       overrun,      // sticky: a key was dropped
    input  logic       overrun_clr
);

    localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW_W-1:0] DW_LAST   = DW_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0] DW_SETTLE = DW_W'(2);
    localparam logic [DW_W-1:0] DW_ONE    = DW_W'(1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD
    } state_t;

    state_t          state;
    logic [3:0]      row_sync1;
    logic [3:0]      rs;
    logic [1:0]      col;
    logic [1:0]      row;
    logic [DW_W-1:0] dw;
    logic [DB_W-1:0] db;

    logic [1:0]      first_row;
    logic            rows_idle;
    logic            emit_ok;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    // Lowest-index low row wins when several are pressed together.
    always_comb begin
        first_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) first_row = 2'(i);
        end
    end

    assign rows_idle = &rs;
    // A read in the emit cycle frees the buffer for the new key.
    assign emit_ok   = !key_valid || key_read;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state     <= ST_SCAN;
            row_sync1 <= 4'b1111;
            rs        <= 4'b1111;
            col       <= 2'd0;
            row       <= 2'd0;
            dw        <= '0;
            db        <= '0;
            ColOut    <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            row_sync1 <= RowIn;
            rs        <= row_sync1;

            // Handshake and flag clearing come first so that an emit or
            // overrun later in this block overrides them.
            if (key_valid && key_read) key_valid <= 1'b0;
            if (overrun_clr)           overrun   <= 1'b0;

            case (state)
                ST_SCAN: begin
                    // The first two cycles of a column are ignored while the
                    // synchronizer still holds rows seen under the old column.
                    if (dw >= DW_SETTLE && !rows_idle) begin
                        row   <= first_row;
                        db    <= '0;
                        state <= ST_DEBOUNCE;
                    end else if (dw == DW_LAST) begin
                        col    <= col + 2'd1;
                        ColOut <= col_drive(col + 2'd1);
                        dw     <= '0;
                    end else begin
                        dw <= dw + DW_ONE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (rs[row]) begin
                        state <= ST_SCAN;
                        dw    <= '0;
                    end else if (db == DB_LAST) begin
                        if (emit_ok) begin
                            key_code  <= {row, col};
                            key_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        db    <= '0;
                        state <= ST_HELD;
                    end else begin
                        db <= db + DB_ONE;
                    end
                end

                ST_HELD: begin
                    // Release needs a full run of all-high samples; any low
                    // row restarts the count.
                    if (!rows_idle) begin
                        db <= '0;
                    end else if (db == DB_LAST) begin
                        db     <= '0;
                        dw     <= '0;
                        col    <= col + 2'd1;
                        ColOut <= col_drive(col + 2'd1);
                        state  <= ST_SCAN;
                    end else begin
                        db <= db + DB_ONE;
                    end
                end

                default: begin
                    state <= ST_SCAN;
                    dw    <= '0;
                    db    <= '0;
                end
            endcase
        end
    end

endmodule
